enter_input_conditioner: RTL and testbench

- Front-end stage for the microprocessor's Enter/Input pair.
- Takes the raw Enter push-button and 8 raw data switches.
- Synchronizes and debounces them, latches the data byte, and presents `Enter`/`Input` to the processor core with a hold-until-taken handshake.
- One press yields exactly one accepted input, however long the button is held or however slowly the control unit reaches its input state.

---
 rtl/enter_input_conditioner.sv | 92 +++++++++
 tb/tb_enter_input_conditioner.sv | 128 ++++++++++++
 2 files changed

// File: rtl/enter_input_conditioner.sv
// enter_input_conditioner: sync + debounce Enter button, latch switch byte, hold Enter until Taken.
// Define ENTER_DEBOUNCE_EN to build the counter debouncer; otherwise the synchronized level is used directly.
module enter_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             EnterBtn,
    input  logic [WIDTH-1:0] SwIn,
    input  logic             Taken,
    output logic             Enter,
    output logic [WIDTH-1:0] Input,
    output logic             Ready
);
    typedef enum logic [1:0] {IDLE, VALID, WAIT_REL} state_t;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
        $error("DEBOUNCE_CYCLES out of range 2..65535");
    end

    logic             btn_s1_q, btn_s2_q, btn_db;
    logic [WIDTH-1:0] sw_s1_q, sw_s2_q, data_q, data_d;
    state_t           state_q, state_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= EnterBtn;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= SwIn;
            sw_s2_q  <= sw_s1_q;
        end
    end

`ifdef ENTER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d, mismatch, flip;
    // The counter only reaches DEBOUNCE_CYCLES-1 under mismatch, where it clears, so it never wraps.
    always_comb begin
        mismatch = btn_s2_q != db_q;
        flip     = mismatch && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        cnt_d    = (!mismatch || flip) ? '0 : cnt_q + 1'b1;
        db_d     = flip ? btn_s2_q : db_q;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end
    assign btn_db = db_q;
`else
    assign btn_db = btn_s2_q;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: if (btn_db) begin
                state_d = VALID;
                data_d  = sw_s2_q;
            end
            VALID:    state_d = Taken ? WAIT_REL : VALID;
            WAIT_REL: state_d = btn_db ? WAIT_REL : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign Enter = state_q == VALID;
    assign Ready = state_q == IDLE;
    assign Input = data_q;
endmodule

// File: tb/tb_enter_input_conditioner.sv
// tb_enter_input_conditioner: directed bench with a byte scoreboard checked on every Enter rise.
module tb_enter_input_conditioner;
    localparam int DEB = 16;
`ifdef ENTER_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 2;
`endif

    logic       Clock = 1'b0, Reset = 1'b1, EnterBtn = 1'b0, Taken = 1'b0;
    logic [7:0] SwIn = 8'h00, Input;
    logic       Enter, Ready;
    logic       prev_enter = 1'b0;
    logic [7:0] sb_q[$];
    int         total = 0, bad = 0;

    enter_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(DEB)) dut (
        .Clock(Clock), .Reset(Reset), .EnterBtn(EnterBtn), .SwIn(SwIn),
        .Taken(Taken), .Enter(Enter), .Input(Input), .Ready(Ready)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        if (Enter === 1'b1 && prev_enter !== 1'b1) begin
            if (sb_q.size() == 0) chk("unexpected_enter", {31'd0, Enter}, 32'd0);
            else chk("sb_input", {24'd0, Input}, {24'd0, sb_q.pop_front()});
        end
        prev_enter = Enter;
    end

    initial begin
        step(2);
        Reset = 1'b0;
        chk("rst_enter", {31'd0, Enter}, 32'd0);
        chk("rst_input", {24'd0, Input}, 32'd0);
        chk("rst_ready", {31'd0, Ready}, 32'd1);
        // clean press
        SwIn = 8'h5A; EnterBtn = 1'b1; sb_q.push_back(8'h5A);
        step(LAT);
        chk("press_early_enter", {31'd0, Enter}, 32'd0);
        chk("press_early_ready", {31'd0, Ready}, 32'd1);
        step(1);
        chk("press_enter", {31'd0, Enter}, 32'd1);
        chk("press_input", {24'd0, Input}, 32'h5A);
        chk("press_ready", {31'd0, Ready}, 32'd0);
        // switches move while VALID
        SwIn = 8'hFF;
        step(5);
        chk("stable_input", {24'd0, Input}, 32'h5A);
        step(30);
        chk("hold_enter", {31'd0, Enter}, 32'd1);
        Taken = 1'b1;
        step(1);
        Taken = 1'b0;
        chk("taken_enter", {31'd0, Enter}, 32'd0);
        step(100);
        chk("held_no_repeat", {31'd0, Enter}, 32'd0);
        chk("held_ready", {31'd0, Ready}, 32'd0);
        EnterBtn = 1'b0;
        step(LAT);
        chk("rel_early_ready", {31'd0, Ready}, 32'd0);
        step(1);
        chk("rel_ready", {31'd0, Ready}, 32'd1);
        // second press captures new byte
        EnterBtn = 1'b1; sb_q.push_back(8'hFF);
        step(LAT + 1);
        chk("press2_enter", {31'd0, Enter}, 32'd1);
        chk("press2_input", {24'd0, Input}, 32'hFF);
        Taken = 1'b1; step(1); Taken = 1'b0;
        EnterBtn = 1'b0;
        step(LAT + 2);
        chk("press2_rearm", {31'd0, Ready}, 32'd1);
`ifdef ENTER_DEBOUNCE_EN
        EnterBtn = 1'b1; step(5);
        EnterBtn = 1'b0; step(3);
        EnterBtn = 1'b1; step(10);
        EnterBtn = 1'b0; step(30);
        chk("bounce_enter", {31'd0, Enter}, 32'd0);
        chk("bounce_ready", {31'd0, Ready}, 32'd1);
`else
        SwIn = 8'h81; sb_q.push_back(8'h81);
        EnterBtn = 1'b1; step(1);
        EnterBtn = 1'b0; step(1);
        chk("glitch_early", {31'd0, Enter}, 32'd0);
        step(1);
        chk("glitch_enter", {31'd0, Enter}, 32'd1);
        chk("glitch_input", {24'd0, Input}, 32'h81);
        Taken = 1'b1; step(1); Taken = 1'b0;
        step(4);
        chk("glitch_rearm", {31'd0, Ready}, 32'd1);
`endif
        // reset while VALID, button kept held
        SwIn = 8'h33; EnterBtn = 1'b1; sb_q.push_back(8'h33);
        step(LAT + 1);
        chk("pre_rst_input", {24'd0, Input}, 32'h33);
        Reset = 1'b1; step(1); Reset = 1'b0;
        chk("mid_rst_enter", {31'd0, Enter}, 32'd0);
        chk("mid_rst_input", {24'd0, Input}, 32'd0);
        chk("mid_rst_ready", {31'd0, Ready}, 32'd1);
        sb_q.push_back(8'h33);
        step(LAT);
        chk("post_rst_early", {31'd0, Enter}, 32'd0);
        step(1);
        chk("post_rst_enter", {31'd0, Enter}, 32'd1);
        chk("post_rst_input", {24'd0, Input}, 32'h33);
        Taken = 1'b1; step(1); Taken = 1'b0;
        EnterBtn = 1'b0;
        step(LAT + 2);
        chk("final_ready", {31'd0, Ready}, 32'd1);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
